// File: rtl/gam_conn_age_memory_pkg.sv
// rtl/gam_conn_age_memory_pkg.sv - shared types, defaults and index helpers for the GAM edge store
package gam_conn_age_memory_pkg;

  localparam int CONN_CLASS_COUNT = 3;
  localparam int CONN_NODE_COUNT  = 8;
  localparam int CONN_AGE_W       = 4;
  localparam int CONN_AGE_MAX     = 3;

  typedef struct packed {
    logic                  present;
    logic [CONN_AGE_W-1:0] age;
  } conn_entry_t;

  typedef enum logic [1:0] {
    OP_INSERT  = 2'd0,
    OP_PRUNE   = 2'd1,
    OP_CLEAR   = 2'd2,
    OP_ILLEGAL = 2'd3
  } conn_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AGE   = 2'd1,
    PRUNE = 2'd2,
    FIN   = 2'd3
  } conn_state_e;

  // Index 0 is reserved in both the class and node dimensions.
  function automatic logic idx_legal(input int unsigned v, input int unsigned cnt);
    return (v != 0) && (v < cnt);
  endfunction

  function automatic logic idx_below(input int unsigned v, input int unsigned cnt);
    return v < cnt;
  endfunction

endpackage

// File: rtl/gam_conn_age_memory_scan_ctrl.sv
// rtl/gam_conn_age_memory_scan_ctrl.sv - gam_conn_scan_ctrl: command FSM plus class/row/column scan counters
module gam_conn_scan_ctrl
  import gam_conn_age_memory_pkg::*;
#(
  parameter  int CLASS_COUNT = CONN_CLASS_COUNT,
  parameter  int NODE_COUNT  = CONN_NODE_COUNT,
  localparam int CLS_W       = $clog2(CLASS_COUNT),
  localparam int ND_W        = $clog2(NODE_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go_age,
  input  logic             i_go_prune,
  input  logic             i_go_fin,
  output conn_state_e      o_state,
  output logic [CLS_W-1:0] o_cls,
  output logic [ND_W-1:0]  o_row,
  output logic [ND_W-1:0]  o_col,
  output logic             o_row_end,
  output logic             o_scan_last,
  output logic             o_wr_en,
  output logic             o_ready,
  output logic             o_done
);

  conn_state_e      r_state;
  conn_state_e      w_next;
  logic [CLS_W-1:0] r_cls;
  logic [ND_W-1:0]  r_row;
  logic [ND_W-1:0]  r_col;
  logic             w_cls_last;
  logic             w_row_last;
  logic             w_col_last;

  assign w_cls_last = (r_cls == CLS_W'(CLASS_COUNT - 1));
  assign w_row_last = (r_row == ND_W'(NODE_COUNT - 1));
  assign w_col_last = (r_col == ND_W'(NODE_COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_go_age)        w_next = AGE;
        else if (i_go_prune) w_next = PRUNE;
        else if (i_go_fin)   w_next = FIN;
      end
      AGE:     if (o_scan_last) w_next = FIN;
      PRUNE:   if (o_scan_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready     = 1'b0;
    o_done      = 1'b0;
    o_wr_en     = 1'b0;
    o_row_end   = 1'b0;
    o_scan_last = 1'b0;
    case (r_state)
      IDLE: o_ready = 1'b1;
      AGE: begin
        o_wr_en     = 1'b1;
        o_scan_last = w_row_last;
      end
      PRUNE: begin
        o_wr_en     = 1'b1;
        o_row_end   = w_col_last;
        o_scan_last = w_col_last & w_row_last & w_cls_last;
      end
      FIN:     o_done = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // Counters park at index 1 while idle so every scan starts on the first legal entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls <= CLS_W'(1);
      r_row <= ND_W'(1);
      r_col <= ND_W'(1);
    end else begin
      case (r_state)
        AGE: r_row <= r_row + ND_W'(1);
        PRUNE: begin
          if (w_col_last) begin
            r_col <= ND_W'(1);
            if (w_row_last) begin
              r_row <= ND_W'(1);
              r_cls <= r_cls + CLS_W'(1);
            end else begin
              r_row <= r_row + ND_W'(1);
            end
          end else begin
            r_col <= r_col + ND_W'(1);
          end
        end
        default: begin
          r_cls <= CLS_W'(1);
          r_row <= ND_W'(1);
          r_col <= ND_W'(1);
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_cls   = r_cls;
  assign o_row   = r_row;
  assign o_col   = r_col;

endmodule

// File: rtl/gam_conn_age_memory.sv
// rtl/gam_conn_age_memory.sv - per-class symmetric edge store with ageing and pruning; CONN_MEM_STATS_EN adds edge_count
module gam_conn_age_memory
  import gam_conn_age_memory_pkg::*;
#(
  parameter  int CLASS_COUNT = CONN_CLASS_COUNT,
  parameter  int NODE_COUNT  = CONN_NODE_COUNT,
  parameter  int AGE_W       = CONN_AGE_W,
  parameter  int AGE_MAX     = CONN_AGE_MAX,
  localparam int CLS_W       = $clog2(CLASS_COUNT),
  localparam int ND_W        = $clog2(NODE_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [CLS_W-1:0]                  cmd_class,
  input  logic [ND_W-1:0]                   cmd_node1,
  input  logic [ND_W-1:0]                   cmd_node2,
  output logic                              done,
  output logic                              err,
  input  logic [CLS_W-1:0]                  q_class,
  input  logic [ND_W-1:0]                   q_node1,
  input  logic [ND_W-1:0]                   q_node2,
  output logic                              q_present,
  output logic [AGE_W-1:0]                  q_age,
  output logic [CLASS_COUNT*NODE_COUNT-1:0] node_invalid
`ifdef CONN_MEM_STATS_EN
  ,
  output logic [15:0]                       edge_count
`endif
);

  conn_entry_t r_mem [CLASS_COUNT][NODE_COUNT][NODE_COUNT];
  logic [CLASS_COUNT-1:0][NODE_COUNT-1:0] r_node_invalid;

  logic [CLS_W-1:0] r_cls;
  logic [ND_W-1:0]  r_n1;
  logic [ND_W-1:0]  r_n2;
  logic             r_survivor;
  logic             r_err;
  logic             r_q_present;
  logic [AGE_W-1:0] r_q_age;

  conn_op_e         w_op;
  conn_state_e      w_state;
  logic [CLS_W-1:0] w_scan_cls;
  logic [ND_W-1:0]  w_row;
  logic [ND_W-1:0]  w_col;
  logic             w_row_end;
  logic             w_scan_last;
  logic             w_wr_en;
  logic             w_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_illegal;
  logic             w_go_age;
  logic             w_go_prune;
  logic             w_go_fin;
  logic             w_do_clear;
  conn_entry_t      w_nb;
  logic             w_age_hit;
  logic [AGE_W-1:0] w_age_inc;
  conn_entry_t      w_pe;
  logic             w_kill;
  logic             w_survive;
  logic             w_q_ok;

  assign w_op     = conn_op_e'(cmd_op);
  assign w_accept = cmd_valid & w_ready;

  assign w_illegal = (w_op == OP_ILLEGAL) ||
                     ((w_op == OP_INSERT) &&
                      !(idx_legal(32'(cmd_class), CLASS_COUNT) &&
                        idx_legal(32'(cmd_node1), NODE_COUNT) &&
                        idx_legal(32'(cmd_node2), NODE_COUNT) &&
                        (cmd_node1 != cmd_node2)));

  assign w_go_age   = w_accept & (w_op == OP_INSERT) & ~w_illegal;
  assign w_go_prune = w_accept & (w_op == OP_PRUNE);
  assign w_do_clear = w_accept & (w_op == OP_CLEAR);
  assign w_go_fin   = w_accept & (w_illegal | (w_op == OP_CLEAR));

  gam_conn_scan_ctrl #(
    .CLASS_COUNT (CLASS_COUNT),
    .NODE_COUNT  (NODE_COUNT)
  ) u_scan_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_go_age    (w_go_age),
    .i_go_prune  (w_go_prune),
    .i_go_fin    (w_go_fin),
    .o_state     (w_state),
    .o_cls       (w_scan_cls),
    .o_row       (w_row),
    .o_col       (w_col),
    .o_row_end   (w_row_end),
    .o_scan_last (w_scan_last),
    .o_wr_en     (w_wr_en),
    .o_ready     (w_ready),
    .o_done      (w_done)
  );

  // Ageing walks row n1 of the latched class; the fresh edge and self-loop are skipped.
  assign w_nb      = r_mem[r_cls][r_n1][w_row];
  assign w_age_hit = w_wr_en && (w_state == AGE) && (w_row != r_n1) &&
                     (w_row != r_n2) && w_nb.present;
  assign w_age_inc = (w_nb.age == '1) ? w_nb.age : w_nb.age + AGE_W'(1);

  assign w_pe      = r_mem[w_scan_cls][w_row][w_col];
  assign w_kill    = w_wr_en && (w_state == PRUNE) && w_pe.present &&
                     (w_pe.age >= AGE_W'(AGE_MAX));
  assign w_survive = r_survivor | (w_wr_en && (w_state == PRUNE) && w_pe.present && !w_kill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CLASS_COUNT; c++)
        for (int a = 0; a < NODE_COUNT; a++)
          for (int b = 0; b < NODE_COUNT; b++)
            r_mem[c][a][b] <= '0;
      r_node_invalid <= '0;
      r_cls          <= '0;
      r_n1           <= '0;
      r_n2           <= '0;
      r_survivor     <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_err <= w_accept & w_illegal;
      if (w_go_age) begin
        r_cls <= cmd_class;
        r_n1  <= cmd_node1;
        r_n2  <= cmd_node2;
        r_mem[cmd_class][cmd_node1][cmd_node2] <= '{present: 1'b1, age: '0};
        r_mem[cmd_class][cmd_node2][cmd_node1] <= '{present: 1'b1, age: '0};
      end
      if (w_do_clear) begin
        for (int c = 0; c < CLASS_COUNT; c++)
          for (int a = 0; a < NODE_COUNT; a++)
            for (int b = 0; b < NODE_COUNT; b++)
              r_mem[c][a][b] <= '0;
        r_node_invalid <= '0;
      end
      if (w_age_hit) begin
        r_mem[r_cls][r_n1][w_row].age <= w_age_inc;
        r_mem[r_cls][w_row][r_n1].age <= w_age_inc;
      end
      // Clearing the mirror too means later rows already see this removal.
      if (w_kill) begin
        r_mem[w_scan_cls][w_row][w_col] <= '0;
        r_mem[w_scan_cls][w_col][w_row] <= '0;
      end
      if (w_row_end) begin
        r_node_invalid[w_scan_cls][w_row] <= ~w_survive;
      end
      r_survivor <= (w_row_end | w_scan_last) ? 1'b0 : w_survive;
    end
  end

  assign w_q_ok = idx_below(32'(q_class), CLASS_COUNT) &&
                  idx_below(32'(q_node1), NODE_COUNT) &&
                  idx_below(32'(q_node2), NODE_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_present <= 1'b0;
      r_q_age     <= '0;
    end else if (w_q_ok) begin
      r_q_present <= r_mem[q_class][q_node1][q_node2].present;
      r_q_age     <= AGE_W'(r_mem[q_class][q_node1][q_node2].age);
    end else begin
      r_q_present <= 1'b0;
      r_q_age     <= '0;
    end
  end

`ifdef CONN_MEM_STATS_EN
  logic [15:0] r_edge_count;
  logic        w_ins_new;

  assign w_ins_new = ~r_mem[cmd_class][cmd_node1][cmd_node2].present;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_count <= '0;
    end else if (w_do_clear) begin
      r_edge_count <= '0;
    end else if (w_go_age && w_ins_new) begin
      r_edge_count <= r_edge_count + 16'd1;
    end else if (w_kill) begin
      r_edge_count <= r_edge_count - 16'd1;
    end
  end

  assign edge_count = r_edge_count;
`endif

  assign cmd_ready    = w_ready;
  assign done         = w_done;
  assign err          = r_err;
  assign q_present    = r_q_present;
  assign q_age        = r_q_age;
  assign node_invalid = r_node_invalid;

endmodule

// File: tb/tb_gam_conn_age_memory.sv
// tb/tb_gam_conn_age_memory.sv - randomized bench for gam_conn_age_memory against a behavioural edge model
module tb_gam_conn_age_memory;

  localparam int CC   = 3;
  localparam int NC   = 8;
  localparam int AMAX = 3;
  localparam int SAT  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_class;
  logic [2:0]  cmd_node1;
  logic [2:0]  cmd_node2;
  logic        done;
  logic        err;
  logic [1:0]  q_class;
  logic [2:0]  q_node1;
  logic [2:0]  q_node2;
  logic        q_present;
  logic [3:0]  q_age;
  logic [23:0] node_invalid;
`ifdef CONN_MEM_STATS_EN
  logic [15:0] edge_count;
`endif

  always #5 clk = ~clk;

  gam_conn_age_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_class    (cmd_class),
    .cmd_node1    (cmd_node1),
    .cmd_node2    (cmd_node2),
    .done         (done),
    .err          (err),
    .q_class      (q_class),
    .q_node1      (q_node1),
    .q_node2      (q_node2),
    .q_present    (q_present),
    .q_age        (q_age),
    .node_invalid (node_invalid)
`ifdef CONN_MEM_STATS_EN
    ,
    .edge_count   (edge_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  bit mp   [4][NC][NC];
  int ma   [4][NC][NC];
  bit minv [CC][NC];
  int mcount;

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < NC; a++)
        for (int b = 0; b < NC; b++) begin
          mp[c][a][b] = 1'b0;
          ma[c][a][b] = 0;
        end
    for (int c = 0; c < CC; c++)
      for (int n = 0; n < NC; n++)
        minv[c][n] = 1'b0;
    mcount = 0;
  endtask

  function automatic bit model_illegal(int op, int c, int a, int b);
    if (op == 3) return 1'b1;
    if (op == 0) return (c == 0) || (c >= CC) || (a == 0) || (b == 0) || (a == b);
    return 1'b0;
  endfunction

  task automatic model_apply(input int op, input int c, input int a, input int b);
    bit surv;
    case (op)
      0: begin
        if (!mp[c][a][b]) mcount++;
        mp[c][a][b] = 1'b1; mp[c][b][a] = 1'b1;
        ma[c][a][b] = 0;    ma[c][b][a] = 0;
        for (int i = 1; i < NC; i++)
          if (i != a && i != b && mp[c][a][i]) begin
            ma[c][a][i] = (ma[c][a][i] >= SAT) ? SAT : ma[c][a][i] + 1;
            ma[c][i][a] = ma[c][a][i];
          end
      end
      1: begin
        for (int cl = 1; cl < CC; cl++)
          for (int i = 1; i < NC; i++) begin
            surv = 1'b0;
            for (int j = 1; j < NC; j++) begin
              if (mp[cl][i][j] && ma[cl][i][j] >= AMAX) begin
                mp[cl][i][j] = 1'b0; mp[cl][j][i] = 1'b0;
                ma[cl][i][j] = 0;    ma[cl][j][i] = 0;
                mcount--;
              end else if (mp[cl][i][j]) begin
                surv = 1'b1;
              end
            end
            minv[cl][i] = !surv;
          end
      end
      2: model_reset();
      default: ;
    endcase
  endtask

  function automatic logic [23:0] exp_invalid();
    logic [23:0] v;
    v = '0;
    for (int c = 0; c < CC; c++)
      for (int n = 0; n < NC; n++)
        v[c*NC+n] = minv[c][n];
    return v;
  endfunction

  task automatic do_cmd(input int op, input int c, input int a, input int b,
                        input int exp_lat, input int exp_err);
    int k;
    @(negedge clk);
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_class = 2'(c);
    cmd_node1 = 3'(a);
    cmd_node2 = 3'(b);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 1;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("latency_op%0d", op), k, exp_lat);
    check($sformatf("err_op%0d", op), int'(err), exp_err);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("ready_after_done", int'(cmd_ready), 1);
  endtask

  task automatic run_cmd(input int op, input int c, input int a, input int b);
    bit ill;
    int lat;
    ill = model_illegal(op, c, a, b);
    if (ill)          lat = 1;
    else if (op == 0) lat = NC;
    else if (op == 1) lat = (CC - 1) * (NC - 1) * (NC - 1) + 1;
    else              lat = 1;
    do_cmd(op, c, a, b, lat, int'(ill));
    if (!ill) model_apply(op, c, a, b);
  endtask

  task automatic qchk(input string tag, input int c, input int a, input int b,
                      input int exp_p, input int exp_age);
    @(negedge clk);
    q_class = 2'(c);
    q_node1 = 3'(a);
    q_node2 = 3'(b);
    @(negedge clk);
    check({tag, "_present"}, int'(q_present), exp_p);
    check({tag, "_age"}, int'(q_age), exp_age);
  endtask

  task automatic check_all(input string tag);
    int pc, pa, pb;
    pc = 0; pa = 0; pb = 0;
    for (int idx = 0; idx <= 4 * NC * NC; idx++) begin
      @(negedge clk);
      if (idx > 0) begin
        check($sformatf("%s_p_%0d_%0d_%0d", tag, pc, pa, pb), int'(q_present), int'(mp[pc][pa][pb]));
        check($sformatf("%s_a_%0d_%0d_%0d", tag, pc, pa, pb), int'(q_age), ma[pc][pa][pb]);
      end
      if (idx < 4 * NC * NC) begin
        pc = idx / (NC * NC);
        pa = (idx / NC) % NC;
        pb = idx % NC;
        q_class = 2'(pc);
        q_node1 = 3'(pa);
        q_node2 = 3'(pb);
      end
    end
    check({tag, "_node_invalid"}, int'(node_invalid), int'(exp_invalid()));
`ifdef CONN_MEM_STATS_EN
    check({tag, "_edge_count"}, int'(edge_count), mcount);
`endif
  endtask

  initial begin
    int k, ndone, r, op, c, a, b;
    int t_done [2];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_class = '0;
    cmd_node1 = '0; cmd_node2 = '0; q_class = '0; q_node1 = '0; q_node2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_q_present", int'(q_present), 0);
    rst_n = 1'b1;
    check_all("reset");

    run_cmd(0, 1, 1, 2);
    qchk("ins12_12", 1, 1, 2, 1, 0);
    qchk("ins12_21", 1, 2, 1, 1, 0);
    qchk("ins12_13", 1, 1, 3, 0, 0);
    check_all("ins12");

    run_cmd(2, 0, 0, 0);
    run_cmd(0, 1, 2, 3);
    run_cmd(0, 1, 2, 4);
    qchk("age1_23", 1, 2, 3, 1, 1);
    run_cmd(0, 1, 2, 5);
    qchk("age2_23", 1, 2, 3, 1, 2);
    qchk("age2_24", 1, 2, 4, 1, 1);
    qchk("age2_25", 1, 2, 5, 1, 0);
    qchk("age2_34", 1, 3, 4, 0, 0);
    check_all("ageing");

    run_cmd(2, 0, 0, 0);
    run_cmd(0, 1, 2, 3);
    for (int n = 0; n < 20; n++) run_cmd(0, 1, 2, (n % 2 == 0) ? 4 : 5);
    qchk("sat_23", 1, 2, 3, 1, 15);
    run_cmd(0, 1, 2, 3);
    qchk("refresh_23", 1, 2, 3, 1, 0);
    check_all("saturate");

    run_cmd(2, 0, 0, 0);
    run_cmd(0, 1, 2, 3);
    run_cmd(0, 1, 2, 4);
    run_cmd(0, 1, 2, 4);
    run_cmd(0, 1, 2, 5);
    qchk("pre_prune_23", 1, 2, 3, 1, 3);
    qchk("pre_prune_24", 1, 2, 4, 1, 1);
    run_cmd(1, 0, 0, 0);
    qchk("prune_23", 1, 2, 3, 0, 0);
    qchk("prune_24", 1, 2, 4, 1, 1);
    check("prune_inv_n3", int'(node_invalid[1*NC+3]), 1);
    check("prune_inv_n2", int'(node_invalid[1*NC+2]), 0);
    check("prune_inv_n4", int'(node_invalid[1*NC+4]), 0);
    check_all("prune");

    run_cmd(0, 1, 4, 4);
    run_cmd(3, 1, 1, 2);
    run_cmd(0, 0, 1, 2);
    run_cmd(0, 3, 1, 2);
    run_cmd(0, 1, 0, 2);
    check_all("illegal");

    // cmd_valid held across a busy INSERT: the second command waits for IDLE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_class = 2'd1; cmd_node1 = 3'd1; cmd_node2 = 3'd3;
    @(posedge clk);
    k = 0; ndone = 0; t_done[0] = 0; t_done[1] = 0;
    while (ndone < 2 && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) cmd_node2 = 3'd4;
      if (k == 4) check("held_busy_ready", int'(cmd_ready), 0);
      if (k == 9) check("held_idle_ready", int'(cmd_ready), 1);
      if (k == 10) cmd_valid = 1'b0;
      if (done) begin
        t_done[ndone] = k;
        ndone++;
      end
    end
    check("held_first_done", t_done[0], NC);
    check("held_second_done", t_done[1], 2 * NC + 1);
    model_apply(0, 1, 1, 3);
    model_apply(0, 1, 1, 4);
    check_all("held");

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 19);
      if (r < 13) begin
        op = 0;
        c = (r < 12) ? $urandom_range(1, 2) : $urandom_range(0, 3);
        a = $urandom_range(1, 5);
        b = $urandom_range(1, 5);
      end else if (r < 16) begin
        op = 1; c = 0; a = 0; b = 0;
      end else if (r == 16) begin
        op = 2; c = 0; a = 0; b = 0;
      end else if (r == 17) begin
        op = 3; c = $urandom_range(0, 3); a = $urandom_range(0, 7); b = $urandom_range(0, 7);
      end else begin
        op = 0; c = $urandom_range(1, 2); a = $urandom_range(0, 7); b = (r == 18) ? a : 0;
      end
      run_cmd(op, c, a, b);
      check_all($sformatf("rand%0d", t));
    end

    run_cmd(0, 1, 2, 3);
    run_cmd(0, 2, 5, 6);
    run_cmd(1, 0, 0, 0);
    run_cmd(0, 1, 6, 7);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", int'(cmd_ready), 1);
    check("midreset_invalid", int'(node_invalid), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_q_present", int'(q_present), 0);
`ifdef CONN_MEM_STATS_EN
    check("midreset_edge_count", int'(edge_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all("midreset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
